// File: rtl/order_tx.sv
// order_tx: buffers 128-bit order words in a small FIFO and frames each one
// as a multi-beat Avalon-ST packet (header, high payload, low payload).
// Optional feature macro: ORDER_TX_CKSUM_EN appends a fourth beat carrying
// the XOR of the header and both payload beats.
module order_tx #(
    parameter int unsigned ORDER_WIDTH   = 128,
    parameter int unsigned TX_DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SEQ_WIDTH     = 32,
    parameter logic [15:0] HDR_TAG       = 16'hA5C3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            order_valid,
    output logic                            order_ready,
    input  logic [ORDER_WIDTH-1:0]          order_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic                            tx_startofpacket,
    output logic                            tx_endofpacket,
    output logic [TX_DATA_WIDTH-1:0]        tx_data,
    output logic [2:0]                      tx_empty,
    output logic [SEQ_WIDTH-1:0]            seq_num,
    output logic [15:0]                     drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        HI,
`ifdef ORDER_TX_CKSUM_EN
        LO,
        CKS
`else
        LO
`endif
    } state_t;

`ifdef ORDER_TX_CKSUM_EN
    localparam state_t LAST_ST = CKS;
`else
    localparam state_t LAST_ST = LO;
`endif

    // FIFO storage and bookkeeping
    logic [ORDER_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_q;
    logic [AW-1:0]            rd_ptr_q;
    logic [LW-1:0]            count_q;
    logic [LW-1:0]            count_d;
    logic [ORDER_WIDTH-1:0]   hold_q;
    logic [15:0]              drop_q;

    // Framer state and registered beat outputs
    state_t                   state_q;
    logic                     tx_valid_q;
    logic                     sop_q;
    logic                     eop_q;
    logic [TX_DATA_WIDTH-1:0] data_q;
    logic [SEQ_WIDTH-1:0]     seq_q;
    logic [SEQ_WIDTH-1:0]     seq_inc;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic pkt_done;

    // Header beat: tag in the top 16 bits, sequence number in the low bits.
    function automatic logic [TX_DATA_WIDTH-1:0] hdr_word(input logic [SEQ_WIDTH-1:0] s);
        logic [TX_DATA_WIDTH-1:0] w;
        w = '0;
        w[SEQ_WIDTH-1:0] = s;
        w[TX_DATA_WIDTH-1 -: 16] = HDR_TAG;
        return w;
    endfunction

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == LW'(FIFO_DEPTH));
    assign order_ready = !reset && !fifo_full;
    assign push        = order_valid && order_ready;
    assign pkt_done    = tx_valid_q && tx_ready && (state_q == LAST_ST);
    assign pop         = !fifo_empty && ((state_q == IDLE) || pkt_done);
    assign seq_inc     = seq_q + SEQ_WIDTH'(1);

    // Occupancy next-state: simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + LW'(1);
        end else if (pop && !push) begin
            count_d = count_q - LW'(1);
        end
    end

    // FIFO array write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= order_data;
        end
    end

    // FIFO pointers, occupancy, holding register and drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            drop_q   <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                hold_q   <= mem_q[rd_ptr_q];
            end
            if (order_valid && !order_ready && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    // Packet framer: walks header/payload beats, holding each until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            data_q     <= '0;
            seq_q      <= '0;
        end else if (pkt_done) begin
            seq_q <= seq_inc;
            if (!fifo_empty) begin
                state_q    <= HDR;
                tx_valid_q <= 1'b1;
                sop_q      <= 1'b1;
                eop_q      <= 1'b0;
                data_q     <= hdr_word(seq_inc);
            end else begin
                state_q    <= IDLE;
                tx_valid_q <= 1'b0;
                sop_q      <= 1'b0;
                eop_q      <= 1'b0;
                data_q     <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q    <= HDR;
                        tx_valid_q <= 1'b1;
                        sop_q      <= 1'b1;
                        eop_q      <= 1'b0;
                        data_q     <= hdr_word(seq_q);
                    end
                end
                HDR: begin
                    if (tx_ready) begin
                        state_q <= HI;
                        sop_q   <= 1'b0;
                        data_q  <= hold_q[ORDER_WIDTH-1 -: TX_DATA_WIDTH];
                    end
                end
                HI: begin
                    if (tx_ready) begin
                        state_q <= LO;
                        data_q  <= hold_q[TX_DATA_WIDTH-1:0];
`ifdef ORDER_TX_CKSUM_EN
                        eop_q   <= 1'b0;
`else
                        eop_q   <= 1'b1;
`endif
                    end
                end
`ifdef ORDER_TX_CKSUM_EN
                LO: begin
                    if (tx_ready) begin
                        state_q <= CKS;
                        eop_q   <= 1'b1;
                        data_q  <= hdr_word(seq_q)
                                 ^ hold_q[ORDER_WIDTH-1 -: TX_DATA_WIDTH]
                                 ^ hold_q[TX_DATA_WIDTH-1:0];
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign tx_valid         = tx_valid_q;
    assign tx_startofpacket = sop_q;
    assign tx_endofpacket   = eop_q;
    assign tx_data          = data_q;
    assign tx_empty         = 3'd0;
    assign seq_num          = seq_q;
    assign drop_cnt         = drop_q;
    assign fifo_level       = count_q;

endmodule

// File: tb/tb_order_tx.sv
// Bench for order_tx: two instances (default and 4-bit sequence) share stimulus
// and are checked every cycle against a queue-based packet model.
module tb_order_tx;

    localparam int unsigned DEPTH = 4;
`ifdef ORDER_TX_CKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         ov;
    logic         tr;
    logic [127:0] od;

    logic         m_rdy, m_v, m_sop, m_eop;
    logic [63:0]  m_d;
    logic [2:0]   m_emp;
    logic [31:0]  m_sq;
    logic [15:0]  m_dc;
    logic [2:0]   m_lvl;

    logic         w_rdy, w_v, w_sop, w_eop;
    logic [63:0]  w_d;
    logic [2:0]   w_emp;
    logic [3:0]   w_sq;
    logic [15:0]  w_dc;
    logic [2:0]   w_lvl;

    always #5 clk = ~clk;

    order_tx dut_m (
        .clk(clk), .reset(rst), .order_valid(ov), .order_ready(m_rdy), .order_data(od),
        .tx_valid(m_v), .tx_ready(tr), .tx_startofpacket(m_sop), .tx_endofpacket(m_eop),
        .tx_data(m_d), .tx_empty(m_emp), .seq_num(m_sq), .drop_cnt(m_dc), .fifo_level(m_lvl)
    );

    order_tx #(.SEQ_WIDTH(4)) dut_w (
        .clk(clk), .reset(rst), .order_valid(ov), .order_ready(w_rdy), .order_data(od),
        .tx_valid(w_v), .tx_ready(tr), .tx_startofpacket(w_sop), .tx_endofpacket(w_eop),
        .tx_data(w_d), .tx_empty(w_emp), .seq_num(w_sq), .drop_cnt(w_dc), .fifo_level(w_lvl)
    );

    // Reference model: pending orders, beats of the packet in flight, counters.
    typedef struct {
        int           kind;   // 0 header, 1 high payload, 2 low payload, 3 checksum
        logic [127:0] ord;
        int unsigned  seq;
    } beat_t;

    logic [127:0] fq[$];
    beat_t        cur[$];
    int unsigned  seq_cnt;
    int unsigned  drops;
    int           total = 0;
    int           bad   = 0;

    function automatic logic [63:0] hdr(input int unsigned s, input int sw);
        logic [63:0] h;
        h = {16'hA5C3, 48'h0};
        h[47:0] = 48'(s) & ((48'd1 << sw) - 48'd1);
        return h;
    endfunction

    function automatic logic [63:0] beat_data(input beat_t b, input int sw);
        case (b.kind)
            0:       return hdr(b.seq, sw);
            1:       return b.ord[127:64];
            2:       return b.ord[63:0];
            default: return hdr(b.seq, sw) ^ b.ord[127:64] ^ b.ord[63:0];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_dut(input string p, input int sw, input logic v, input logic s,
                             input logic e, input logic [63:0] d, input logic [2:0] emp,
                             input logic rdy, input logic [2:0] lvl, input logic [47:0] sq,
                             input logic [15:0] dc);
        bit ev;
        ev = (cur.size() > 0);
        chk({p, ".valid"}, 64'(v), 64'(ev));
        if (ev) begin
            chk({p, ".data"}, d, beat_data(cur[0], sw));
            chk({p, ".sop"}, 64'(s), 64'(cur[0].kind == 0));
            chk({p, ".eop"}, 64'(e), 64'(cur[0].kind == NB - 1));
        end else begin
            chk({p, ".sop_idle"}, 64'(s), 64'd0);
            chk({p, ".eop_idle"}, 64'(e), 64'd0);
        end
        chk({p, ".empty"}, 64'(emp), 64'd0);
        chk({p, ".ready"}, 64'(rdy), 64'(!rst && (fq.size() < DEPTH)));
        chk({p, ".level"}, 64'(lvl), 64'(fq.size()));
        chk({p, ".seq"}, 64'(sq), 64'(48'(seq_cnt) & ((48'd1 << sw) - 48'd1)));
        chk({p, ".drop"}, 64'(dc), 64'(drops));
    endtask

    task automatic model_reset();
        fq.delete();
        cur.delete();
        seq_cnt = 0;
        drops   = 0;
    endtask

    // Advance the model across one clock edge given this cycle's inputs.
    task automatic model_edge();
        bit           pop_now;
        bit           rdy;
        int           sz;
        logic [127:0] o;
        if (rst) begin
            model_reset();
            return;
        end
        sz      = fq.size();
        rdy     = (sz < DEPTH);
        pop_now = 1'b0;
        if (cur.size() == 0) begin
            pop_now = (sz > 0);
        end else if (tr) begin
            void'(cur.pop_front());
            if (cur.size() == 0) begin
                seq_cnt++;
                pop_now = (sz > 0);
            end
        end
        if (ov && !rdy && drops < 32'hFFFF) drops++;
        if (pop_now) begin
            o = fq.pop_front();
            for (int k = 0; k < NB; k++) begin
                beat_t b;
                b.kind = k;
                b.ord  = o;
                b.seq  = seq_cnt;
                cur.push_back(b);
            end
        end
        if (ov && rdy) fq.push_back(od);
    endtask

    task automatic step();
        #1;
        check_dut("m", 32, m_v, m_sop, m_eop, m_d, m_emp, m_rdy, m_lvl, 48'(m_sq), m_dc);
        check_dut("w", 4,  w_v, w_sop, w_eop, w_d, w_emp, w_rdy, w_lvl, 48'(w_sq), w_dc);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d);
        ov = 1'b1;
        od = d;
        step();
        ov = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_kind(input int k, input string tag);
        int n = 0;
        while (!(cur.size() > 0 && cur[0].kind == k) && n < 30) begin
            step();
            n++;
        end
        chk(tag, 64'(n < 30), 64'd1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] ordv;
        int           peak;
        int           beats;

        rst = 1'b1; ov = 1'b0; tr = 1'b1; od = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        do_reset();

        // Single order with fixed pattern
        ordv = 128'h0123456789ABCDEF_FEDCBA9876543210;
        send(ordv);
        step();
        chk("single_hdr", m_d, 64'hA5C3_0000_0000_0000);
        chk("single_sop", 64'(m_sop), 64'd1);
        idle(NB + 2);
        chk("single_seq", 64'(m_sq), 64'd1);

        // Back-to-back orders
        do_reset();
        peak = 0; beats = 0;
        for (int i = 0; i < 3; i++) begin
            send(rnd128());
            if (int'(m_lvl) > peak) peak = int'(m_lvl);
            if (m_v) beats++;
        end
        for (int i = 0; i < 3 * NB + 3; i++) begin
            step();
            if (int'(m_lvl) > peak) peak = int'(m_lvl);
            if (m_v) beats++;
        end
        chk("b2b_peak", 64'(peak), 64'd2);
        chk("b2b_beats", 64'(beats), 64'(3 * NB));

        // Backpressure on the high payload beat
        ordv = rnd128();
        send(ordv);
        wait_kind(1, "bp_wait_hi");
        tr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 64'(m_v), 64'd1);
            chk("bp_data", m_d, ordv[127:64]);
        end
        tr = 1'b1;
        idle(NB + 2);

        // Overflow while the framer is stalled on a header
        do_reset();
        tr = 1'b0;
        send(rnd128());
        idle(2);
        for (int i = 0; i < 6; i++) send(rnd128());
        chk("ovf_level", 64'(m_lvl), 64'd4);
        chk("ovf_ready", 64'(m_rdy), 64'd0);
        chk("ovf_drop", 64'(m_dc), 64'd2);
        tr = 1'b1;
        idle(5 * NB + 5);

        // Sequence wrap on the 4-bit instance
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send(rnd128());
            step();
            chk($sformatf("wrap_hdr%0d", i), w_d, {16'hA5C3, 48'(i % 16)});
            idle(NB - 2);
        end
        idle(NB + 2);
        chk("wrap_w_seq", 64'(w_sq), 64'd1);
        chk("wrap_m_seq", 64'(m_sq), 64'd17);

        // Reset in the middle of a packet
        send(rnd128());
        wait_kind(1, "rst_wait_hi");
        rst = 1'b1;
        step();
        chk("rst_valid", 64'(m_v), 64'd0);
        chk("rst_sop", 64'(m_sop), 64'd0);
        chk("rst_eop", 64'(m_eop), 64'd0);
        chk("rst_data", m_d, 64'd0);
        chk("rst_seq", 64'(m_sq), 64'd0);
        chk("rst_level", 64'(m_lvl), 64'd0);
        chk("rst_ready", 64'(m_rdy), 64'd0);
        rst = 1'b0;
        idle(2);

        // Random traffic, backpressure and occasional reset
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            ov  = ($urandom_range(0, 2) != 0);
            od  = rnd128();
            tr  = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0; ov = 1'b0; tr = 1'b1;
        idle(6 * NB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
